fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have ports, one per line:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- PC_Write  input  1  1 = PC may update; 0 = load-use stall, PC held
- IF_ID_Write  input  1  1 = IF/ID may load; 0 = IF/ID held
- PC_Mux_select  input  2  00 seq (PC+4), 01 branch_target, 10 jump_target, 11 reserved
- IF_ID_Mux_select  input  1  1 = flush IF/ID to bubble
- branch_target  input  32  redirect address for 01
- jump_target  input  32  redirect address for 10
- imem_req  output  1  instruction memory request
- imem_addr  output  32  request address
- imem_ready  input  1  response valid; completes the request
- imem_rdata  input  32  instruction word, valid with imem_ready
- IF_ID_PC  output  32  PC of the instruction in IF/ID
- IF_ID_Instr  output  32  instruction in IF/ID
- IF_ID_Valid  output  1  1 = IF/ID holds a real instruction
- fetch_busy  output  1  1 = request outstanding (WAIT or DROP)
- bubble_cnt  output  32  perf counter (see Configuration)
- redirect_cnt  output  32  perf counter (see Configuration)

Function
REQ-003 SHALL implement states IDLE, WAIT, HOLD, DROP; IDLE lasts one cycle after reset release, then WAIT.
REQ-004 SHALL keep imem_req high in WAIT and DROP, with imem_addr stable until imem_ready is sampled high; at most one request outstanding.
REQ-005 In WAIT, on imem_ready with IF_ID_Write=1 and no flush: SHALL load IF/ID {PC, imem_rdata, Valid=1}, set PC<=PC+4, issue the next request at PC+4 next cycle (remain WAIT).
REQ-006 In WAIT, on imem_ready with IF_ID_Write=0: SHALL capture imem_rdata in a one-entry hold buffer and go to HOLD; imem_req low in HOLD.
REQ-007 In HOLD, when IF_ID_Write=1 and no flush: SHALL move the buffer into IF/ID with Valid=1, PC<=PC+4, go to WAIT.
REQ-008 When IF_ID_Write=1 and no instruction is available (WAIT without imem_ready, DROP, IDLE): SHALL load IF/ID with Instr=32'h0000_0000, Valid=0, and increment bubble_cnt.
REQ-009 Redirect = PC_Write=1 and PC_Mux_select in {01,10}: SHALL set PC to the selected target next edge, discard any held or arriving instruction, increment redirect_cnt.
REQ-010 Redirect in WAIT without imem_ready SHALL go to DROP; in DROP the response is discarded on imem_ready, then WAIT at the new PC.
REQ-011 Redirect coinciding with imem_ready, or in HOLD, SHALL go directly to WAIT at the target.
REQ-012 IF_ID_Mux_select=1 SHALL load IF/ID with Instr=0, Valid=0, IF_ID_PC unchanged, with priority over IF_ID_Write and over REQ-005/007 loads.
REQ-013 PC_Write=0 SHALL hold PC regardless of PC_Mux_select; responses still complete per REQ-006.
REQ-014 PC_Mux_select=11 with PC_Write=1 SHALL behave as 00.
REQ-015 PC arithmetic SHALL be 32-bit modulo (32'hFFFF_FFFC + 4 = 0).

Reset
REQ-016 While rst_n=0, asynchronously: state=IDLE, PC=RESET_PC, imem_req=0, imem_addr=RESET_PC, IF_ID_PC=0, IF_ID_Instr=0, IF_ID_Valid=0, hold buffer empty, fetch_busy=0, both counters 0.
REQ-017 Reset asserted mid-request SHALL abandon the request; no stale response is delivered after release.

Configuration
REQ-018 Macro FETCH_PERF_CNT_EN: defined = bubble_cnt and redirect_cnt count per REQ-008/009, wrapping at 2^32; undefined = both ports constant 0 and no counter flops.

Verification
REQ-019 Reset release, imem_ready=1 every cycle, all selects 0 -> IF_ID_PC 0,4,8 with Valid=1 on consecutive cycles after the IDLE cycle.
REQ-020 imem_ready delayed 3 cycles -> 3 bubbles (Valid=0), bubble_cnt=3 (macro on), then instruction at PC 0.
REQ-021 IF_ID_Write=0, PC_Write=0 for 2 cycles while response arrives -> HOLD, IF/ID unchanged, instruction delivered on release, PC advances once.
REQ-022 PC_Mux_select=01, branch_target=32'h0000_0100, during WAIT -> DROP, old response discarded, next imem_addr=0x100, redirect_cnt=1.
REQ-023 IF_ID_Mux_select=1 with imem_ready=1 -> IF/ID Valid=0, Instr=0.
REQ-024 rst_n low while imem_req=1 -> outputs at reset values immediately, first post-reset imem_addr=RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage -- instruction fetch with a single-outstanding memory request,
// a one-entry hold buffer for back-pressure, redirect handling and the IF/ID
// pipeline register.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   PC_Write            1 = PC may update (0 = load-use stall)
//   IF_ID_Write         1 = IF/ID may load
//   PC_Mux_select[1:0]  00 seq, 01 branch_target, 10 jump_target, 11 = seq
//   IF_ID_Mux_select    1 = flush IF/ID to a bubble
//   branch_target, jump_target   redirect addresses
//   imem_req/imem_addr  request to instruction memory (held until imem_ready)
//   imem_ready/imem_rdata        response handshake and data
//   IF_ID_PC/Instr/Valid         IF/ID pipeline register
//   fetch_busy          request outstanding (WAIT or DROP)
//   bubble_cnt, redirect_cnt     perf counters
//
// Build option
//   FETCH_PERF_CNT_EN   defined: counters live and wrap at 2^32;
//                       undefined: both counter ports tie to 0, no flops.
// -----------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PC_Write,
  input  logic        IF_ID_Write,
  input  logic [1:0]  PC_Mux_select,
  input  logic        IF_ID_Mux_select,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid,
  output logic        fetch_busy,
  output logic [31:0] bubble_cnt,
  output logic [31:0] redirect_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD, S_DROP} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;   // address of the request being discarded
  logic [31:0] hold_q, hold_d;
  logic [31:0] if_id_pc_q, if_id_pc_d;
  logic [31:0] if_id_instr_q, if_id_instr_d;
  logic        if_id_valid_q, if_id_valid_d;

  logic        redirect;
  logic [31:0] redirect_tgt;
  logic        accept;
  logic        deliver;
  logic [31:0] deliver_instr;
  logic        bubble_evt;

  // An instruction is only consumed when both the PC and IF/ID may advance;
  // otherwise a completed response parks in the hold buffer so it is not lost.
  assign redirect     = PC_Write && (PC_Mux_select == 2'b01 || PC_Mux_select == 2'b10);
  assign redirect_tgt = (PC_Mux_select == 2'b01) ? branch_target : jump_target;
  assign accept       = PC_Write && IF_ID_Write && !IF_ID_Mux_select;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    drop_addr_d   = drop_addr_q;
    hold_d        = hold_q;
    deliver       = 1'b0;
    deliver_instr = hold_q;
    unique case (state_q)
      S_IDLE: begin
        state_d = S_WAIT;
        if (redirect) pc_d = redirect_tgt;
      end
      S_WAIT: begin
        if (redirect) begin
          pc_d = redirect_tgt;
          if (!imem_ready) begin
            // request already on the bus: let it finish, then throw it away
            state_d     = S_DROP;
            drop_addr_d = pc_q;
          end
        end else if (imem_ready) begin
          if (accept) begin
            deliver       = 1'b1;
            deliver_instr = imem_rdata;
            pc_d          = pc_q + 32'd4;
          end else begin
            hold_d  = imem_rdata;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = redirect_tgt;
          state_d = S_WAIT;
        end else if (accept) begin
          deliver = 1'b1;
          pc_d    = pc_q + 32'd4;
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        if (redirect)   pc_d    = redirect_tgt;
        if (imem_ready) state_d = S_WAIT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // IF/ID: flush beats everything; a bubble is counted only when IF/ID was
  // free to load and nothing was available to put in it.
  always_comb begin
    if_id_pc_d    = if_id_pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_valid_d = if_id_valid_q;
    bubble_evt    = 1'b0;
    if (IF_ID_Mux_select) begin
      if_id_instr_d = 32'h0;
      if_id_valid_d = 1'b0;
    end else if (deliver) begin
      if_id_pc_d    = pc_q;
      if_id_instr_d = deliver_instr;
      if_id_valid_d = 1'b1;
    end else if (IF_ID_Write) begin
      if_id_instr_d = 32'h0;
      if_id_valid_d = 1'b0;
      bubble_evt    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      drop_addr_q   <= RESET_PC;
      hold_q        <= 32'h0;
      if_id_pc_q    <= 32'h0;
      if_id_instr_q <= 32'h0;
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      drop_addr_q   <= drop_addr_d;
      hold_q        <= hold_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  assign imem_req    = (state_q == S_WAIT) || (state_q == S_DROP);
  assign imem_addr   = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign fetch_busy  = imem_req;
  assign IF_ID_PC    = if_id_pc_q;
  assign IF_ID_Instr = if_id_instr_q;
  assign IF_ID_Valid = if_id_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] redirect_cnt_q, redirect_cnt_d;

  always_comb begin
    bubble_cnt_d   = bubble_cnt_q + {31'd0, bubble_evt};
    redirect_cnt_d = redirect_cnt_q + {31'd0, redirect};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bubble_cnt_q   <= 32'h0;
      redirect_cnt_q <= 32'h0;
    end else begin
      bubble_cnt_q   <= bubble_cnt_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign bubble_cnt   = bubble_cnt_q;
  assign redirect_cnt = redirect_cnt_q;
`else
  logic perf_unused;
  assign perf_unused  = bubble_evt ^ redirect;
  assign bubble_cnt   = 32'h0;
  assign redirect_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk, rst_n;
  logic        PC_Write, IF_ID_Write, IF_ID_Mux_select;
  logic [1:0]  PC_Mux_select;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, imem_ready, IF_ID_Valid, fetch_busy;
  logic [31:0] imem_addr, imem_rdata, IF_ID_PC, IF_ID_Instr, bubble_cnt, redirect_cnt;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n),
    .PC_Write(PC_Write), .IF_ID_Write(IF_ID_Write),
    .PC_Mux_select(PC_Mux_select), .IF_ID_Mux_select(IF_ID_Mux_select),
    .branch_target(branch_target), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .IF_ID_PC(IF_ID_PC), .IF_ID_Instr(IF_ID_Instr), .IF_ID_Valid(IF_ID_Valid),
    .fetch_busy(fetch_busy), .bubble_cnt(bubble_cnt), .redirect_cnt(redirect_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic        pw, iw;
    logic [1:0]  sel;
    logic        fl, rdy;
    logic [31:0] rdata, jt;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_bub, e_red;
  } vec_t;

  function automatic vec_t mk(logic pw, logic iw, logic [1:0] sel, logic fl, logic rdy,
                              logic [31:0] rdata, logic [31:0] jt, logic e_req,
                              logic [31:0] e_addr, logic e_valid, logic [31:0] e_pc,
                              logic [31:0] e_instr, logic [31:0] e_bub, logic [31:0] e_red);
    vec_t v;
    v.pw = pw; v.iw = iw; v.sel = sel; v.fl = fl; v.rdy = rdy; v.rdata = rdata; v.jt = jt;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_instr = e_instr; v.e_bub = e_bub; v.e_red = e_red;
    return v;
  endfunction

  task automatic drive(input logic pw, input logic iw, input logic [1:0] sel, input logic fl,
                       input logic rdy, input logic [31:0] rdata);
    PC_Write = pw; IF_ID_Write = iw; PC_Mux_select = sel; IF_ID_Mux_select = fl;
    imem_ready = rdy; imem_rdata = rdata;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'd0, imem_req}, 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'd0, IF_ID_Valid}, 32'd0);
    chk({tag, "_pc"},    IF_ID_PC, 32'h0);
    chk({tag, "_instr"}, IF_ID_Instr, 32'h0);
    chk({tag, "_busy"},  {31'd0, fetch_busy}, 32'd0);
    chk({tag, "_bub"},   bubble_cnt, 32'h0);
    chk({tag, "_red"},   redirect_cnt, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl[20];

  initial begin
    logic [31:0] exp_pc, rd;
    sb_t e;
    bit got;

    // Every row is one clock edge starting right after reset release.
    // Columns: pw iw sel fl rdy rdata jt | pre-edge req addr | post-edge valid pc instr bub red
    tbl[0]  = mk(1,1,2'b00,0,0,32'h0,        32'hDEAD_0000, 0,32'h0,        0,32'h0,        32'h0,        1,0);
    tbl[1]  = mk(1,1,2'b00,0,0,32'h0,        32'hDEAD_0000, 1,32'h0,        0,32'h0,        32'h0,        2,0);
    tbl[2]  = mk(1,1,2'b00,0,0,32'h0,        32'hDEAD_0000, 1,32'h0,        0,32'h0,        32'h0,        3,0);
    tbl[3]  = mk(1,1,2'b00,0,1,32'hA000_0001,32'hDEAD_0000, 1,32'h0,        1,32'h0,        32'hA000_0001,3,0);
    tbl[4]  = mk(0,0,2'b00,0,1,32'hA000_0002,32'hDEAD_0000, 1,32'h4,        1,32'h0,        32'hA000_0001,3,0);
    tbl[5]  = mk(0,0,2'b00,0,0,32'h0,        32'hDEAD_0000, 0,32'h4,        1,32'h0,        32'hA000_0001,3,0);
    tbl[6]  = mk(1,1,2'b00,0,0,32'h0,        32'hDEAD_0000, 0,32'h4,        1,32'h4,        32'hA000_0002,3,0);
    tbl[7]  = mk(1,1,2'b00,0,0,32'h0,        32'hDEAD_0000, 1,32'h8,        0,32'h4,        32'h0,        4,0);
    tbl[8]  = mk(1,1,2'b01,0,0,32'h0,        32'hDEAD_0000, 1,32'h8,        0,32'h4,        32'h0,        5,1);
    tbl[9]  = mk(1,1,2'b00,0,1,32'hA000_0003,32'hDEAD_0000, 1,32'h8,        0,32'h4,        32'h0,        6,1);
    tbl[10] = mk(1,1,2'b00,0,1,32'hA000_0004,32'hDEAD_0000, 1,32'h100,      1,32'h100,      32'hA000_0004,6,1);
    tbl[11] = mk(1,1,2'b00,1,1,32'hA000_0005,32'hDEAD_0000, 1,32'h104,      0,32'h100,      32'h0,        6,1);
    tbl[12] = mk(1,1,2'b00,0,0,32'h0,        32'hDEAD_0000, 0,32'h104,      1,32'h104,      32'hA000_0005,6,1);
    tbl[13] = mk(1,1,2'b10,0,1,32'hA000_0006,32'h0000_0200, 1,32'h108,      0,32'h104,      32'h0,        7,2);
    tbl[14] = mk(1,1,2'b11,0,1,32'hA000_0007,32'hDEAD_0000, 1,32'h200,      1,32'h200,      32'hA000_0007,7,2);
    tbl[15] = mk(0,1,2'b01,0,0,32'h0,        32'hDEAD_0000, 1,32'h204,      0,32'h200,      32'h0,        8,2);
    tbl[16] = mk(1,1,2'b00,0,1,32'hA000_0008,32'hDEAD_0000, 1,32'h204,      1,32'h204,      32'hA000_0008,8,2);
    tbl[17] = mk(1,1,2'b10,0,1,32'hA000_0006,32'hFFFF_FFFC, 1,32'h208,      0,32'h204,      32'h0,        9,3);
    tbl[18] = mk(1,1,2'b00,0,1,32'hA000_0009,32'hDEAD_0000, 1,32'hFFFF_FFFC,1,32'hFFFF_FFFC,32'hA000_0009,9,3);
    tbl[19] = mk(1,1,2'b00,0,0,32'h0,        32'hDEAD_0000, 1,32'h0,        0,32'hFFFF_FFFC,32'h0,        10,3);

    // ---- reset state ----
    rst_n = 1'b0;
    branch_target = 32'h0000_0100;
    jump_target   = 32'hDEAD_0000;
    drive(1, 1, 2'b00, 0, 0, 32'h0);
    #12;
    chk_reset_outputs("reset");

    // ---- back-to-back stream through the scoreboard ----
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("stream_idle_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk); #1;
    chk("stream_idle_valid", {31'd0, IF_ID_Valid}, 32'd0);
    exp_pc = 32'h0;
    for (int i = 0; i < 6; i++) begin
      rd = $urandom;
      drive(1, 1, 2'b00, 0, 1, rd);
      sb.push_back('{pc: exp_pc, instr: rd});
      @(negedge clk);
      chk($sformatf("stream%0d_addr", i), imem_addr, exp_pc);
      @(posedge clk); #1;
      if (IF_ID_Valid) begin
        e = sb.pop_front();
        chk($sformatf("stream%0d_pc", i), IF_ID_PC, e.pc);
        chk($sformatf("stream%0d_instr", i), IF_ID_Instr, e.instr);
      end else begin
        checks++; failures++;
        $display("FAIL stream%0d_valid actual=0 expected=1", i);
      end
      exp_pc += 32'd4;
    end
    chk("stream_sb_empty", sb.size(), 32'd0);

    // ---- reset mid-request: immediate reset values, stale data never delivered ----
    drive(1, 1, 2'b00, 0, 0, 32'h0);
    @(negedge clk);
    chk("midrst_pre_req", {31'd0, imem_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 1, 2'b00, 0, 1, 32'hBAD0_BAD0);
    @(posedge clk); #1;
    chk("midrst_idle_valid", {31'd0, IF_ID_Valid}, 32'd0);
    chk("midrst_first_addr", imem_addr, 32'h0);
    drive(1, 1, 2'b00, 0, 1, 32'h1234_5678);
    sb.push_back('{pc: 32'h0, instr: 32'h1234_5678});
    got = 1'b0;
    for (int c = 0; c < 4 && !got; c++) begin
      @(posedge clk); #1;
      if (IF_ID_Valid) got = 1'b1;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL midrst_timeout actual=no_valid expected=valid");
      sb.delete();
    end else begin
      e = sb.pop_front();
      chk("midrst_pc", IF_ID_PC, e.pc);
      chk("midrst_instr", IF_ID_Instr, e.instr);
    end

    // ---- table-driven multi-cycle sequence from a fresh reset ----
    drive(1, 1, 2'b00, 0, 0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    foreach (tbl[i]) begin
      drive(tbl[i].pw, tbl[i].iw, tbl[i].sel, tbl[i].fl, tbl[i].rdy, tbl[i].rdata);
      jump_target = tbl[i].jt;
      @(negedge clk);
      chk($sformatf("r%0d_req", i),  {31'd0, imem_req}, {31'd0, tbl[i].e_req});
      chk($sformatf("r%0d_busy", i), {31'd0, fetch_busy}, {31'd0, tbl[i].e_req});
      chk($sformatf("r%0d_addr", i), imem_addr, tbl[i].e_addr);
      @(posedge clk); #1;
      chk($sformatf("r%0d_valid", i), {31'd0, IF_ID_Valid}, {31'd0, tbl[i].e_valid});
      chk($sformatf("r%0d_pc", i),    IF_ID_PC, tbl[i].e_pc);
      chk($sformatf("r%0d_instr", i), IF_ID_Instr, tbl[i].e_instr);
      chk($sformatf("r%0d_bub", i),   bubble_cnt, PERF ? tbl[i].e_bub : 32'h0);
      chk($sformatf("r%0d_red", i),   redirect_cnt, PERF ? tbl[i].e_red : 32'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
